// File: rtl/prog_pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_pattern_detector_pkg
// Purpose  : Shared FSM state encoding and pattern-length clamp helper.
// Revision : 1.0 - initial release
// ============================================================================
package prog_pattern_detector_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // A zero length would never compare anything, so treat it as one bit.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_pattern_match_counter.sv
`default_nettype none
// ============================================================================
// Module   : prog_pattern_match_counter
// Purpose  : Saturating match counter; clear wins over a same-cycle increment.
// Revision : 1.0 - initial release
// ============================================================================
module prog_pattern_match_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clr)
            r_count <= '0;
        else if (inc && (r_count != {CW{1'b1}}))
            r_count <= r_count + CW'(1);
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/prog_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module   : prog_pattern_detector
// Purpose  : Programmable serial pattern detector with per-bit mask, variable
//            length and overlap control. Optional saturating match counter is
//            enabled by defining PROG_PATTERN_DETECTOR_MATCH_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prog_pattern_detector
    import prog_pattern_detector_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_load,
    input  logic [W-1:0]           cfg_pattern,
    input  logic [W-1:0]           cfg_mask,
    input  logic [$clog2(W+1)-1:0] cfg_len,
    input  logic                   cfg_overlap,
    input  logic                   din_valid,
    input  logic                   din,
    output logic                   seen,
    output logic                   armed
`ifdef PROG_PATTERN_DETECTOR_MATCH_COUNT_EN
    ,
    output logic [CW-1:0]          match_count,
    input  logic                   count_clr
`endif
);

    localparam int              LW        = $clog2(W+1);
    localparam logic [LW-1:0]   c_len_max = LW'(W);

    logic [W-1:0]  r_pattern;
    logic [W-1:0]  r_mask;
    logic [LW-1:0] r_len;
    logic          r_overlap;
    logic [W-1:0]  r_hist;
    logic [LW-1:0] r_fill;
    state_t        r_state;
    logic          r_seen;

    logic [W-1:0]  w_hist_next;
    logic [W-1:0]  w_len_mask;
    logic          w_hit;
    logic [LW-1:0] w_fill_inc;
    logic [LW-1:0] w_fill_next;
    state_t        w_state_next;
    logic          w_match;

    assign w_hist_next = {r_hist[W-2:0], din};
    // Shifting by the full width yields zero, so len==W selects every bit.
    assign w_len_mask  = ~({W{1'b1}} << r_len);
    assign w_hit       = (((w_hist_next ^ r_pattern) & r_mask & w_len_mask) == '0);
    assign w_fill_inc  = (r_fill == c_len_max) ? r_fill : r_fill + LW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_next;
            r_fill  <= w_fill_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        w_match      = 1'b0;
        if (cfg_load) begin
            w_state_next = FILL;
            w_fill_next  = '0;
        end else if (din_valid) begin
            w_fill_next = w_fill_inc;
            if ((r_state == ARMED) || (w_fill_inc >= r_len)) begin
                w_state_next = ARMED;
                w_match      = w_hit;
                // Non-overlapping mode needs len fresh bits before the next match.
                if (w_hit && !r_overlap) begin
                    w_state_next = FILL;
                    w_fill_next  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= '0;
            r_mask    <= '1;
            r_len     <= c_len_max;
            r_overlap <= 1'b1;
            r_hist    <= '0;
            r_seen    <= 1'b0;
        end else begin
            r_seen <= w_match;
            if (cfg_load) begin
                r_pattern <= cfg_pattern;
                r_mask    <= cfg_mask;
                r_len     <= LW'(clamp_len(32'(cfg_len), W));
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
            end else if (din_valid) begin
                r_hist <= w_hist_next;
            end
        end
    end

    assign seen  = r_seen;
    assign armed = (r_state == ARMED);

`ifdef PROG_PATTERN_DETECTOR_MATCH_COUNT_EN
    prog_pattern_match_counter #(
        .CW (CW)
    ) u_match_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (count_clr),
        .inc   (r_seen),
        .count (match_count)
    );
`endif

endmodule
`default_nettype wire
